// File: rtl/bip_word_tx.sv
// bip_word_tx: byte serializer between the BIP datapath and uart_tx.
// Result words are queued in a small word FIFO. Each word is then sent as two
// UART frames, low byte first and high byte second, which is the order the
// host-side receiver uses to rebuild the word.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a queued word; pops the head word when one is present
//   SEND_LO | o_tx_start pulse, low byte on o_tx_data
//   WAIT_LO | low byte held until uart_tx reports the frame done
//   SEND_HI | o_tx_start pulse, high byte on o_tx_data
//   WAIT_HI | high byte held until uart_tx reports the frame done
//
// Ports:
//   i_clk       system clock
//   i_reset     synchronous reset, active-low
//   i_data      word to transmit (NBITS_D bits)
//   i_valid     i_data valid this cycle
//   o_ready     FIFO can accept a word this cycle
//   o_tx_start  one-cycle frame start pulse to uart_tx
//   o_tx_data   byte presented to uart_tx
//   i_tx_done   uart_tx frame-complete pulse
//   o_busy      serializer not in IDLE
//   o_count     words currently stored in the FIFO
module bip_word_tx #(
  parameter int NBITS_D   = 16,
  parameter int DBIT      = 8,
  parameter int DEPTH_LOG = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_D-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic [DEPTH_LOG:0] o_count
);

  localparam int DEPTH = 2**DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_LO = 3'd1,
    WAIT_LO = 3'd2,
    SEND_HI = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [NBITS_D-1:0]   mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic [DBIT-1:0]      word_hi_r;
  logic [DBIT-1:0]      tx_data_r;
  logic                 push, pop;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign o_ready    = i_reset && (count < FULL);
  assign push       = i_valid && o_ready;
  assign pop        = (state == IDLE) && (count != '0);

  assign o_tx_start = (state == SEND_LO) || (state == SEND_HI);
  assign o_tx_data  = tx_data_r;
  assign o_busy     = (state != IDLE);
  assign o_count    = count;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (count != '0) state_nxt = SEND_LO;
      SEND_LO: state_nxt = WAIT_LO;
      WAIT_LO: if (i_tx_done) state_nxt = SEND_HI;
      SEND_HI: state_nxt = WAIT_HI;
      WAIT_HI: if (i_tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_hi_r <= '0;
      tx_data_r <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        word_hi_r <= mem[rd_ptr][NBITS_D-1:DBIT];
        // Low byte is loaded as SEND_LO is entered so it is valid with the pulse.
        tx_data_r <= mem[rd_ptr][DBIT-1:0];
      end

      if ((state == WAIT_LO) && i_tx_done) tx_data_r <= word_hi_r;

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_word_tx.sv
module tb_bip_word_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [2:0]  count;

  logic        done_model;
  logic        done_spur;
  logic        hold_done;
  int          done_delay;
  int          mcnt;

  int          checks;
  int          failures;
  int          mon_starts;
  logic        prev_start;
  logic [7:0]  last_byte;
  logic [7:0]  sb [$];

  always #5 clk = ~clk;

  assign tx_done = done_model | done_spur;

  bip_word_tx #(.NBITS_D(16), .DBIT(8), .DEPTH_LOG(2)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_data     (data),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_count    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the word is presented across the next rising edge.
  task automatic push(input logic [15:0] w, input logic exp_ready);
    check("push_ready", ready, exp_ready);
    data  = w;
    valid = 1'b1;
    if (exp_ready) begin
      sb.push_back(w[7:0]);
      sb.push_back(w[15:8]);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy && count == 3'd0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, ok, 1'b1);
  endtask

  // uart_tx stand-in: done pulse done_delay cycles after each start.
  initial begin
    done_model = 1'b0;
    mcnt = 0;
    forever begin
      @(negedge clk);
      done_model = 1'b0;
      if (!rst_n) mcnt = 0;
      else if (tx_start) mcnt = done_delay;
      else if (mcnt > 0 && !hold_done) begin
        mcnt--;
        if (mcnt == 0) done_model = 1'b1;
      end
    end
  end

  // Output monitor: every start pops the next expected byte.
  initial begin
    prev_start = 1'b0;
    last_byte  = 8'h00;
    mon_starts = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          mon_starts++;
          check("start_not_back_to_back", prev_start, 1'b0);
          check("sb_has_expected_byte", sb.size() != 0, 1'b1);
          if (sb.size() != 0) check("tx_byte", tx_data, sb.pop_front());
          last_byte = tx_data;
        end else if (busy) begin
          check("tx_data_stable", tx_data, last_byte);
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin
    int base;
    logic ok;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    data = 16'h0000;
    done_spur = 1'b0;
    hold_done = 1'b0;
    done_delay = 20;

    // 1: reset
    repeat (5) begin
      @(negedge clk);
      check("rst_ready", ready, 1'b0);
      check("rst_start", tx_start, 1'b0);
      check("rst_data", tx_data, 8'h00);
      check("rst_count", count, 3'd0);
      check("rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_count", count, 3'd0);
    check("post_rst_busy", busy, 1'b0);

    // 2: single word, latency and byte order
    base = mon_starts;
    push(16'hA55A, 1'b1);
    check("t2_count_after_push", count, 3'd1);
    check("t2_no_start_yet", tx_start, 1'b0);
    check("t2_idle_after_push", busy, 1'b0);
    @(negedge clk);
    check("t2_start_at_2", tx_start, 1'b1);
    check("t2_lo_byte", tx_data, 8'h5A);
    check("t2_busy", busy, 1'b1);
    check("t2_count_popped", count, 3'd0);
    wait_drain("t2_drain", 200);
    check("t2_starts", mon_starts - base, 2);
    check("t2_idle", busy, 1'b0);

    // 3: fill while done is withheld
    hold_done = 1'b1;
    done_delay = 3;
    base = mon_starts;
    for (int i = 1; i <= 5; i++) push(16'(i), 1'b1);
    check("t3_ready_full", ready, 1'b0);
    check("t3_count_full", count, 3'd4);
    check("t3_busy", busy, 1'b1);

    // 4: full FIFO, pop and refused push in the same cycle
    data = 16'hDEAD;
    valid = 1'b1;
    hold_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("t4_ready_while_full", ready, 1'b0);
      @(negedge clk);
      if (count != 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    check("t4_pop_seen", ok, 1'b1);
    check("t4_count_dec", count, 3'd3);
    check("t4_ready_back", ready, 1'b1);
    wait_drain("t4_drain", 500);
    check("t4_starts", mon_starts - base, 10);

    // 5: spurious done in IDLE and SEND_LO
    hold_done = 1'b1;
    base = mon_starts;
    done_spur = 1'b1;
    @(negedge clk);
    done_spur = 1'b0;
    check("t5_idle_spur_busy", busy, 1'b0);
    check("t5_idle_spur_count", count, 3'd0);
    push(16'hBEEF, 1'b1);
    done_spur = 1'b1;
    check("t5_idle_pending", count, 3'd1);
    @(negedge clk);
    check("t5_start", tx_start, 1'b1);
    check("t5_lo_byte", tx_data, 8'hEF);
    @(negedge clk);
    done_spur = 1'b0;
    check("t5_wait_lo_no_start", tx_start, 1'b0);
    check("t5_wait_lo_busy", busy, 1'b1);
    check("t5_wait_lo_data", tx_data, 8'hEF);
    repeat (5) @(negedge clk);
    check("t5_no_advance", mon_starts - base, 1);
    hold_done = 1'b0;
    wait_drain("t5_drain", 200);
    check("t5_starts", mon_starts - base, 2);

    // 6: reset in WAIT_HI with two words queued
    hold_done = 1'b1;
    push(16'h1111, 1'b1);
    push(16'h2222, 1'b1);
    push(16'h3333, 1'b1);
    base = mon_starts;
    hold_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mon_starts - base >= 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    hold_done = 1'b1;
    check("t6_reach_send_hi", ok, 1'b1);
    @(negedge clk);
    check("t6_wait_hi_busy", busy, 1'b1);
    check("t6_wait_hi_count", count, 3'd2);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_count", count, 3'd0);
    check("t6_rst_start", tx_start, 1'b0);
    check("t6_rst_data", tx_data, 8'h00);
    check("t6_rst_ready", ready, 1'b0);
    rst_n = 1'b1;
    hold_done = 1'b0;
    base = mon_starts;
    repeat (30) @(negedge clk);
    check("t6_no_start_after_rst", mon_starts - base, 0);
    check("t6_idle_after_rst", busy, 1'b0);
    push(16'h1234, 1'b1);
    wait_drain("t6_drain", 200);
    check("t6_starts", mon_starts - base, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
